pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the 5-stage pipelined core. It supplies the instruction and its address to the IF/ID register and honours the core's PC_Write stall.
- Owns the fetch PC and a small prefetch buffer. It talks to a variable-latency instruction memory over a req/ack handshake.
- Provides a redirect port so branch/jump resolution can be added without reworking fetch.

Parameters:
- DEPTH, 2, prefetch buffer entries; power of two, >=2.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- PAGE_BITS, 8, PC increment wraps inside bits [PAGE_BITS-1:2]; bits [31:PAGE_BITS] are preserved. 8 matches the core's 64-word instruction memory.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- PC_Write  in  1  from core hazard unit; 1=consume head instruction, 0=stall (hold head)
- Redirect  in  1  flush buffer and restart fetch at Redirect_Addr
- Redirect_Addr  in  32  new fetch address; bits [1:0] ignored (forced 0)
- IM_Req  out  1  instruction memory request, registered
- IM_Addr  out  32  request address, stable while IM_Req=1
- IM_Ack  in  1  memory response valid; sampled only while IM_Req=1
- IM_Data  in  32  instruction word, valid with IM_Ack
- Instr  out  32  head instruction to IF/ID
- Instr_Addr  out  32  address of head instruction
- Instr_Valid  out  1  head entry present
- Fetch_PC  out  32  next address to be requested

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- State after reset:
  - Fetch_PC=RESET_PC; buffer empty; state IDLE.
  - IM_Req=0; IM_Addr=RESET_PC.
  - Instr=32'h0; Instr_Addr=32'h0; Instr_Valid=0.
- Increment rule: next = {PC[31:PAGE_BITS], PC[PAGE_BITS-1:2]+1, 2'b00}. Example with PAGE_BITS=8: 0x0000_00FC -> 0x0000_0000; 0x0000_01FC -> 0x0000_0100.
- Buffer: circular FIFO of {addr, instr}, DEPTH entries, with count register.
  - Instr/Instr_Addr are driven combinationally from the head entry when count>0; both are 0 when empty.
  - Instr_Valid = (count>0).
- Pop: occurs when Instr_Valid && PC_Write && !Redirect. While PC_Write=0, head outputs hold bit-stable.
- Push: occurs on IM_Ack while in REQ. The entry is {IM_Addr, IM_Data}, and Fetch_PC advances by the increment rule in the same cycle.
- Push and pop in the same cycle: both are legal, including at count=DEPTH, because the pop frees the slot; count is unchanged.
- FSM:
  - IDLE: if (count + 0) < DEPTH, then IM_Req<=1, IM_Addr<=Fetch_PC, go to REQ.
  - REQ: hold IM_Req/IM_Addr until IM_Ack.
    - On ack, if (count_after_update) < DEPTH, issue next request back-to-back: IM_Req stays 1, IM_Addr<=incremented PC, remain in REQ.
    - On ack otherwise: IM_Req<=0, go to IDLE.
  - DISCARD: entered on Redirect while in REQ without IM_Ack in that cycle.
    - IM_Req and the old IM_Addr are held (the handshake is never abandoned).
    - On IM_Ack the data is dropped, IM_Req<=0, go to IDLE.
- Outstanding requests: at most one.
- Memory response timing: may respond in the first cycle IM_Req=1 (zero-wait) or any later cycle.
- Redirect (highest priority):
  - Same cycle: count<=0, head/tail pointers reset, pop suppressed.
  - Fetch_PC<={Redirect_Addr[31:2],2'b00}.
  - From REQ with IM_Ack in the same cycle: data dropped, go to IDLE.
  - From REQ without IM_Ack: go to DISCARD.
  - Redirect while in DISCARD: Fetch_PC updated again; remain in DISCARD.
  - Instr_Valid=0 in the cycle after a redirect.
- Reset mid-operation: the outstanding request is abandoned, IM_Req=0 next cycle. The memory model must drop the transaction on reset.
- Throughput: with a zero-wait memory and PC_Write=1 continuously, one instruction is delivered per cycle after a 2-cycle initial fill latency (reset release -> Instr_Valid).

Test Plan:
- Zero-wait memory, PC_Write=1 after reset -> Instr_Addr sequence 0x00,0x04,0x08,... one per cycle; Instr_Valid rises 2 cycles after rst_n=1.
- PC_Write=0 for 5 cycles with buffer full (DEPTH=2) -> IM_Req deasserts; Instr/Instr_Addr stable; on release, addresses continue with no gaps and no duplicates.
- 3-cycle-latency memory -> IM_Addr stable while IM_Req=1; exactly one push per IM_Ack; Fetch_PC steps by 4 per ack.
- Redirect to 0x0000_0043 while a request for 0x10 is outstanding -> DISCARD; the 0x10 data never appears on Instr; next valid Instr_Addr=0x0000_0040.
- Fetch_PC=0x0000_01FC, PAGE_BITS=8 -> next IM_Addr=0x0000_0100.
- rst_n=0 for one cycle mid-request with buffer holding 2 entries -> next cycle IM_Req=0, Instr_Valid=0, Fetch_PC=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch front end. It owns the fetch PC, keeps a small
// circular prefetch buffer of {addr, instr} pairs, and talks to a variable-latency
// instruction memory with at most one request in flight.
module pc_fetch_unit #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          PAGE_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_Write,
   input  logic        Redirect,
   input  logic [31:0] Redirect_Addr,
   output logic        IM_Req,
   output logic [31:0] IM_Addr,
   input  logic        IM_Ack,
   input  logic [31:0] IM_Data,
   output logic [31:0] Instr,
   output logic [31:0] Instr_Addr,
   output logic        Instr_Valid,
   output logic [31:0] Fetch_PC
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);
   localparam logic [PAGE_BITS-3:0]   PAGE_ONE = (PAGE_BITS-2)'(1);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          im_req_q, im_req_d;
   logic [31:0]   im_addr_q, im_addr_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   buf_addr_q [DEPTH];
   logic [31:0]   buf_data_q [DEPTH];

   logic          push, pop;
   logic [CW-1:0] count_upd;

   // Word increment that wraps inside the page; upper address bits are kept.
   function automatic logic [31:0] inc_pc(input logic [31:0] pc);
      logic [31:0] r;
      r = pc;
      r[PAGE_BITS-1:2] = pc[PAGE_BITS-1:2] + PAGE_ONE;
      r[1:0] = 2'b00;
      return r;
   endfunction

   // A redirect drops both the arriving word and the head consumption.
   assign push      = (state_q == REQ) && IM_Ack && !Redirect;
   assign pop       = (count_q != '0) && PC_Write && !Redirect;
   assign count_upd = count_q + CW'(push) - CW'(pop);

   // Next-state, request and buffer-pointer logic; redirect overrides everything.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      im_req_d   = im_req_q;
      im_addr_d  = im_addr_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_upd;

      if (push) begin
         tail_d     = tail_q + PW'(1);
         fetch_pc_d = inc_pc(fetch_pc_q);
      end
      if (pop) head_d = head_q + PW'(1);

      if (Redirect) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         fetch_pc_d = Redirect_Addr & 32'hFFFF_FFFC;
         case (state_q)
            REQ: begin
               if (IM_Ack) begin
                  im_req_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  // The memory still owes us a word; keep the handshake alive.
                  state_d = DISCARD;
               end
            end
            DISCARD: begin
               if (IM_Ack) begin
                  im_req_d = 1'b0;
                  state_d  = IDLE;
               end
            end
            default: ;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (count_q < DEPTH_C) begin
                  im_req_d  = 1'b1;
                  im_addr_d = fetch_pc_q;
                  state_d   = REQ;
               end
            end
            REQ: begin
               if (IM_Ack) begin
                  if (count_upd < DEPTH_C) begin
                     // Back-to-back request for the following word.
                     im_addr_d = inc_pc(fetch_pc_q);
                  end else begin
                     im_req_d = 1'b0;
                     state_d  = IDLE;
                  end
               end
            end
            DISCARD: begin
               if (IM_Ack) begin
                  im_req_d = 1'b0;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         im_req_q   <= 1'b0;
         im_addr_q  <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         im_req_q   <= im_req_d;
         im_addr_q  <= im_addr_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Buffer storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr_q[tail_q] <= im_addr_q;
         buf_data_q[tail_q] <= IM_Data;
      end
   end

   assign IM_Req      = im_req_q;
   assign IM_Addr     = im_addr_q;
   assign Fetch_PC    = fetch_pc_q;
   assign Instr_Valid = (count_q != '0);
   assign Instr       = Instr_Valid ? buf_data_q[head_q] : 32'h0;
   assign Instr_Addr  = Instr_Valid ? buf_addr_q[head_q] : 32'h0;

endmodule
